// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared types, constants and floor-vector helpers for the elevator request unit
package elevator_pkg;

    localparam int MAX_FLOORS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_e;

    typedef logic [MAX_FLOORS-1:0] floor_vec_t;

    // Isolates the least significant set bit (0 when v is 0).
    function automatic floor_vec_t lowest_one(input floor_vec_t v);
        return v & (~v + floor_vec_t'(1));
    endfunction

    // Isolates the most significant set bit (0 when v is 0).
    function automatic floor_vec_t highest_one(input floor_vec_t v);
        floor_vec_t r;
        r = '0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if (v[i]) r = floor_vec_t'(1) << i;
        end
        return r;
    endfunction

    // Floors strictly below a one-hot position; only meaningful for one-hot input.
    function automatic floor_vec_t mask_below(input floor_vec_t oh);
        return oh - floor_vec_t'(1);
    endfunction

    // Floors strictly above a one-hot position; only meaningful for one-hot input.
    function automatic floor_vec_t mask_above(input floor_vec_t oh);
        return ~(mask_below(oh) | oh);
    endfunction

    function automatic logic is_onehot(input floor_vec_t v);
        return (v != '0) && ((v & (v - floor_vec_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/elevator_request_unit_if.sv
// rtl/elevator_request_unit_if.sv - link between the request unit and the motion stage
interface elevator_request_unit_if #(
    parameter int FLOORS = 4
);
    import elevator_pkg::*;

    logic [FLOORS-1:0] current_floor;
    logic              arrived;
    logic [FLOORS-1:0] target_floor;
    logic              target_valid;
    logic              dir_up;

    // Request unit side: publishes the target, consumes the car position.
    modport master (
        input  current_floor,
        input  arrived,
        output target_floor,
        output target_valid,
        output dir_up
    );

    // Motion stage side.
    modport slave (
        output current_floor,
        output arrived,
        input  target_floor,
        input  target_valid,
        input  dir_up
    );

endinterface

// File: rtl/elevator_request_unit_debounce_filter.sv
// rtl/elevator_request_unit_debounce_filter.sv - per-button synchroniser, counter debounce and rising-edge pulse
module debounce_filter
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;

    // Count consecutive samples that differ from the accepted level; any sample
    // matching it (i.e. a bounce back) restarts the count from zero.
    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Synchroniser, counter and filtered level registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/elevator_request_unit.sv
// rtl/elevator_request_unit.sv - debounced call latch with SCAN target selection (optional CALL_CANCEL_EN)
module elevator_request_unit
    import elevator_pkg::*;
#(
    parameter int FLOORS          = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [FLOORS-1:0]       bt_floor,
    output logic [FLOORS-1:0]       pending_calls,
    output logic                    busy,
    elevator_request_unit_if.master car
);

    logic [FLOORS-1:0] rise;
    logic [FLOORS-1:0] pending_q, pending_d;
    state_e            state_q, state_d;
    logic [FLOORS-1:0] target_q, target_d;
    logic              target_valid_q, target_valid_d;
    logic              dir_up_q, dir_up_d;

    floor_vec_t        cur16;
    logic              cur_ok;
    logic [FLOORS-1:0] clr, set_v, cancel, above, below;

    for (genvar i = 0; i < FLOORS; i++) begin : g_btn
        debounce_filter #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk (clk),
            .rst (rst),
            .btn (bt_floor[i]),
            .rise(rise[i])
        );
    end

    // Next pending set: new calls latch, arrival clears the car's floor (clear wins).
    always_comb begin
        cur16  = floor_vec_t'(car.current_floor);
        cur_ok = is_onehot(cur16);
        clr    = (car.arrived && cur_ok) ? car.current_floor : '0;
`ifdef CALL_CANCEL_EN
        set_v  = rise & ~pending_q;
        cancel = rise & pending_q;
`else
        set_v  = rise;
        cancel = '0;
`endif
        pending_d = (pending_q | set_v) & ~clr & ~cancel;
        above     = FLOORS'(mask_above(cur16)) & pending_d;
        below     = FLOORS'(mask_below(cur16)) & pending_d;
    end

    // SCAN direction decision and the registered target it implies; an invalid
    // car position freezes the decision and the published target.
    always_comb begin
        state_d        = state_q;
        target_d       = target_q;
        target_valid_d = target_valid_q;
        dir_up_d       = dir_up_q;
        if (cur_ok) begin
            case (state_q)
                IDLE: begin
                    if (above != '0)      state_d = UP;
                    else if (below != '0) state_d = DOWN;
                end
                UP: begin
                    if (above == '0) state_d = (below != '0) ? DOWN : IDLE;
                end
                DOWN: begin
                    if (below == '0) state_d = (above != '0) ? UP : IDLE;
                end
                default: state_d = IDLE;
            endcase
            case (state_d)
                UP: begin
                    target_d       = FLOORS'(lowest_one(floor_vec_t'(above)));
                    target_valid_d = 1'b1;
                    dir_up_d       = 1'b1;
                end
                DOWN: begin
                    target_d       = FLOORS'(highest_one(floor_vec_t'(below)));
                    target_valid_d = 1'b1;
                    dir_up_d       = 1'b0;
                end
                default: begin
                    target_d       = '0;
                    target_valid_d = 1'b0;
                end
            endcase
        end
    end

    // Pending register, FSM state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q      <= '0;
            state_q        <= IDLE;
            target_q       <= '0;
            target_valid_q <= 1'b0;
            dir_up_q       <= 1'b1;
        end else begin
            pending_q      <= pending_d;
            state_q        <= state_d;
            target_q       <= target_d;
            target_valid_q <= target_valid_d;
            dir_up_q       <= dir_up_d;
        end
    end

    assign pending_calls    = pending_q;
    assign busy             = (state_q != IDLE);
    assign car.target_floor = target_q;
    assign car.target_valid = target_valid_q;
    assign car.dir_up       = dir_up_q;

endmodule
